// File: rtl/pq_request_arbiter_if.sv
// Bundle of the requester-side and queue-side signals of the priority-queue arbiter.
// The arbiter uses the slave view; the clients and the queue drive through the master view.
interface pq_request_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16
);
   logic [NUM_REQ-1:0]            i_req_valid;
   logic [2*NUM_REQ-1:0]          i_req_op;
   logic [DATA_WIDTH*NUM_REQ-1:0] i_req_data;
   logic [NUM_REQ-1:0]            o_req_ready;
   logic [NUM_REQ-1:0]            o_rsp_valid;
   logic [DATA_WIDTH-1:0]         o_rsp_data;
   logic                          o_rsp_err;
   logic                          o_busy;
   logic                          o_q_wrt;
   logic                          o_q_read;
   logic [DATA_WIDTH-1:0]         o_q_data;
   logic                          i_q_full;
   logic                          i_q_empty;
   logic [DATA_WIDTH-1:0]         i_q_data;

   modport slave (
      input  i_req_valid, i_req_op, i_req_data, i_q_full, i_q_empty, i_q_data,
      output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_busy,
             o_q_wrt, o_q_read, o_q_data
   );

   modport master (
      output i_req_valid, i_req_op, i_req_data, i_q_full, i_q_empty, i_q_data,
      input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err, o_busy,
             o_q_wrt, o_q_read, o_q_data
   );
endinterface

// File: rtl/pq_request_arbiter.sv
// Round-robin arbiter sharing one priority queue among NUM_REQ clients.
// Each accepted op is turned into a single-cycle queue pulse, the queue is given
// SETTLE_CYCLES to update, then a one-cycle response goes back to the owner.
module pq_request_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 16,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic               CLK,
   input  logic               RSTn,
   pq_request_arbiter_if.slave bus
);
   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

   localparam logic [1:0] OP_ENQ     = 2'b00;
   localparam logic [1:0] OP_DEQ     = 2'b01;
   localparam logic [1:0] OP_REPLACE = 2'b10;
   localparam logic [1:0] OP_PEEK    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ISSUE  = 2'b01,
      ST_SETTLE = 2'b10,
      ST_RESP   = 2'b11
   } state_t;

   state_t                state_r;
   state_t                next_state_s;
   logic [ID_W-1:0]       ptr_r;
   logic [CNT_W-1:0]      cnt_r;
   logic [ID_W-1:0]       id_r;
   logic [1:0]            op_r;
   logic [DATA_WIDTH-1:0] key_r;
   logic                  full_r;
   logic                  empty_r;
   logic [DATA_WIDTH-1:0] top_r;

   logic [NUM_REQ-1:0]    grant_s;
   logic [ID_W-1:0]       grant_id_s;
   logic                  grant_hit_s;
   logic                  accept_s;
   logic [1:0]            sel_op_s;
   logic [DATA_WIDTH-1:0] sel_key_s;

   logic [NUM_REQ-1:0]    ready_s;
   logic [NUM_REQ-1:0]    rsp_valid_s;
   logic [DATA_WIDTH-1:0] rsp_data_s;
   logic                  rsp_err_s;
   logic                  q_wrt_s;
   logic                  q_read_s;
   logic [DATA_WIDTH-1:0] q_data_s;

   // Requester index base+step, wrapped into 0..NUM_REQ-1.
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int step);
      int sum;
      sum = int'(base) + step;
      if (sum >= NUM_REQ) begin
         sum = sum - NUM_REQ;
      end else begin
         sum = sum;
      end
      return ID_W'(sum);
   endfunction

   // Round-robin scan from the pointer upward; first valid requester wins.
   always_comb begin
      grant_s     = '0;
      grant_id_s  = '0;
      grant_hit_s = 1'b0;
      sel_op_s    = 2'b00;
      sel_key_s   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         logic [ID_W-1:0] idx;
         logic            take;
         idx         = wrap_add(ptr_r, k);
         take        = !grant_hit_s && bus.i_req_valid[idx];
         grant_s     = take ? (grant_s | (NUM_REQ'(1) << idx)) : grant_s;
         grant_id_s  = take ? idx : grant_id_s;
         grant_hit_s = grant_hit_s | take;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         sel_op_s  = (grant_id_s == ID_W'(k)) ? bus.i_req_op[2*k +: 2] : sel_op_s;
         sel_key_s = (grant_id_s == ID_W'(k)) ? bus.i_req_data[DATA_WIDTH*k +: DATA_WIDTH] : sel_key_s;
      end
   end

   // A grant is only offered in IDLE and never while reset is asserted.
   assign accept_s = (state_r == ST_IDLE) && RSTn && grant_hit_s;

   // Next-state and output decode from the state and the latched request.
   always_comb begin
      next_state_s = state_r;
      ready_s      = '0;
      rsp_valid_s  = '0;
      rsp_data_s   = '0;
      rsp_err_s    = 1'b0;
      q_wrt_s      = 1'b0;
      q_read_s     = 1'b0;
      q_data_s     = '0;
      case (state_r)
         ST_IDLE: begin
            ready_s      = (RSTn == 1'b1) ? grant_s : '0;
            next_state_s = accept_s ? ST_ISSUE : ST_IDLE;
         end
         ST_ISSUE: begin
            case (op_r)
               OP_ENQ:     q_wrt_s = !full_r;
               OP_DEQ:     q_read_s = !empty_r;
               OP_REPLACE: begin
                  // On an empty queue a replace degenerates to a plain insert.
                  q_wrt_s  = 1'b1;
                  q_read_s = !empty_r;
               end
               OP_PEEK:    q_wrt_s = 1'b0;
               default:    q_wrt_s = 1'b0;
            endcase
            q_data_s     = q_wrt_s ? key_r : '0;
            next_state_s = ST_SETTLE;
         end
         ST_SETTLE: begin
            next_state_s = (cnt_r <= CNT_W'(1)) ? ST_RESP : ST_SETTLE;
         end
         ST_RESP: begin
            rsp_valid_s[id_r] = 1'b1;
            case (op_r)
               OP_ENQ: begin
                  rsp_err_s  = full_r;
                  rsp_data_s = bus.i_q_data;
               end
               OP_DEQ: begin
                  rsp_err_s  = empty_r;
                  rsp_data_s = empty_r ? '0 : top_r;
               end
               OP_REPLACE: begin
                  rsp_err_s  = 1'b0;
                  rsp_data_s = empty_r ? bus.i_q_data : top_r;
               end
               OP_PEEK: begin
                  rsp_err_s  = empty_r;
                  rsp_data_s = empty_r ? '0 : top_r;
               end
               default: begin
                  rsp_err_s  = 1'b0;
                  rsp_data_s = '0;
               end
            endcase
            next_state_s = ST_IDLE;
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // State register, round-robin pointer, settle counter and request capture.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_r <= ST_IDLE;
         ptr_r   <= '0;
         cnt_r   <= '0;
         id_r    <= '0;
         op_r    <= 2'b00;
         key_r   <= '0;
         full_r  <= 1'b0;
         empty_r <= 1'b0;
         top_r   <= '0;
      end else begin
         state_r <= next_state_s;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  id_r    <= grant_id_s;
                  op_r    <= sel_op_s;
                  key_r   <= sel_key_s;
                  full_r  <= bus.i_q_full;
                  empty_r <= bus.i_q_empty;
                  top_r   <= bus.i_q_data;
                  ptr_r   <= wrap_add(grant_id_s, 1);
               end
            end
            ST_ISSUE:  cnt_r <= CNT_W'(SETTLE_CYCLES);
            ST_SETTLE: cnt_r <= cnt_r - CNT_W'(1);
            default:   cnt_r <= cnt_r;
         endcase
      end
   end

   assign bus.o_req_ready = ready_s;
   assign bus.o_rsp_valid = rsp_valid_s;
   assign bus.o_rsp_data  = rsp_data_s;
   assign bus.o_rsp_err   = rsp_err_s;
   assign bus.o_busy      = (state_r != ST_IDLE);
   assign bus.o_q_wrt     = q_wrt_s;
   assign bus.o_q_read    = q_read_s;
   assign bus.o_q_data    = q_data_s;
endmodule

// File: tb/tb_pq_request_arbiter.sv
// Directed bench for pq_request_arbiter with a behavioural max-first priority queue.
module tb_pq_request_arbiter;
   localparam int QS = 8;
   localparam logic [1:0] OP_ENQ = 2'b00, OP_DEQ = 2'b01, OP_REP = 2'b10, OP_PEEK = 2'b11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic q_clr = 1'b1;
   logic [3:0]  r_valid = 4'b0000;
   logic [1:0]  r_op [4];
   logic [15:0] r_dat [4];
   int rem [4];

   logic [QS-1:0][15:0] q_mem = '0;
   int q_cnt = 0;

   int vectors = 0, miscompares = 0, cyc = 0;
   int wrt_cnt = 0, read_cnt = 0, both_cnt = 0;
   logic prev_pulse = 1'b0;
   int gnt_id[$], gnt_cyc[$], rsp_id[$], rsp_cyc[$], rsp_dat[$], rsp_err[$];

   int e2_id [10] = '{1, 3, 1, 3, 1, 3, 1, 3, 1, 3};
   int e2_dat[10] = '{40, 30, 30, 20, 20, 10, 10, 0, 0, 0};
   int e2_err[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

   pq_request_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(16)) bus ();

   pq_request_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .SETTLE_CYCLES(2)) dut (
      .CLK(clk), .RSTn(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   assign bus.i_req_valid = r_valid;
   for (genvar g = 0; g < 4; g++) begin : g_pack
      assign bus.i_req_op[2*g +: 2]    = r_op[g];
      assign bus.i_req_data[16*g +: 16] = r_dat[g];
   end
   assign bus.i_q_full  = (q_cnt == QS);
   assign bus.i_q_empty = (q_cnt == 0);
   assign bus.i_q_data  = (q_cnt > 0) ? q_mem[0] : 16'h0000;

   function automatic logic [QS-1:0][15:0] q_pop(input logic [QS-1:0][15:0] a);
      logic [QS-1:0][15:0] r;
      for (int i = 0; i < QS - 1; i++) r[i] = a[i+1];
      r[QS-1] = 16'h0000;
      return r;
   endfunction

   function automatic logic [QS-1:0][15:0] q_ins(input logic [QS-1:0][15:0] a, input int n,
                                                 input logic [15:0] v);
      logic [QS-1:0][15:0] r;
      int p;
      r = a;
      p = n;
      while (p > 0 && r[p-1] < v) begin
         r[p] = r[p-1];
         p--;
      end
      r[p] = v;
      return r;
   endfunction

   // Behavioural priority queue: largest key at index 0.
   always @(posedge clk) begin
      if (q_clr) begin
         q_cnt <= 0;
      end else if (bus.o_q_wrt && bus.o_q_read && q_cnt > 0) begin
         q_mem <= q_ins(q_pop(q_mem), q_cnt - 1, bus.o_q_data);
      end else if (bus.o_q_wrt && q_cnt < QS) begin
         q_mem <= q_ins(q_mem, q_cnt, bus.o_q_data);
         q_cnt <= q_cnt + 1;
      end else if (bus.o_q_read && q_cnt > 0) begin
         q_mem <= q_pop(q_mem);
         q_cnt <= q_cnt - 1;
      end
   end

   function automatic int oh2id(input logic [3:0] v);
      case (v)
         4'b0001: return 0;
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         default: return 9;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic [1:0] id, input logic [1:0] op, input logic [15:0] d,
                          input int n);
      r_op[id]    = op;
      r_dat[id]   = d;
      rem[id]     = n;
      r_valid[id] = (n > 0);
   endtask

   task automatic clear_logs();
      gnt_id.delete(); gnt_cyc.delete();
      rsp_id.delete(); rsp_cyc.delete(); rsp_dat.delete(); rsp_err.delete();
      wrt_cnt = 0; read_cnt = 0; both_cnt = 0;
   endtask

   // One clock: per-cycle invariants and logging at the falling edge, then advance.
   task automatic step();
      logic [3:0] acc;
      logic pulse;
      @(negedge clk);
      pulse = bus.o_q_wrt | bus.o_q_read;
      chk("ready_onehot0", 32'($onehot0(bus.o_req_ready)), 32'd1);
      chk("rsp_valid_onehot0", 32'($onehot0(bus.o_rsp_valid)), 32'd1);
      chk("grant_while_busy", 32'((bus.o_req_ready != 4'b0000) && bus.o_busy), 32'd0);
      chk("pulse_outside_issue", 32'(pulse && (!bus.o_busy || bus.o_rsp_valid != 4'b0000)), 32'd0);
      chk("pulse_width", 32'(pulse && prev_pulse), 32'd0);
      chk("rsp_idle_zero", 32'((bus.o_rsp_valid == 4'b0000) &&
                               (bus.o_rsp_err || bus.o_rsp_data != 16'h0000)), 32'd0);
      prev_pulse = pulse;
      if (bus.o_q_wrt) wrt_cnt++;
      if (bus.o_q_read) read_cnt++;
      if (bus.o_q_wrt && bus.o_q_read) both_cnt++;
      acc = bus.o_req_ready & r_valid;
      if (acc != 4'b0000) begin
         gnt_id.push_back(oh2id(acc));
         gnt_cyc.push_back(cyc);
         if (oh2id(acc) < 4) rem[2'(oh2id(acc))]--;
      end
      if (bus.o_rsp_valid != 4'b0000) begin
         rsp_id.push_back(oh2id(bus.o_rsp_valid));
         rsp_cyc.push_back(cyc);
         rsp_dat.push_back(int'(bus.o_rsp_data));
         rsp_err.push_back(int'(bus.o_rsp_err));
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (rem[2'(i)] <= 0) r_valid[2'(i)] = 1'b0;
      end
   endtask

   task automatic run_rsp(input int n, input int budget);
      int b;
      b = budget;
      while (rsp_id.size() < n && b > 0) begin
         step();
         b--;
      end
      chk("rsp_count_or_timeout", 32'(rsp_id.size()), 32'(n));
   endtask

   task automatic check_rsp(input int k, input int id, input int dat, input int err);
      if (k < rsp_id.size() && k < gnt_cyc.size()) begin
         chk($sformatf("rsp%0d_id", k), 32'(rsp_id[k]), 32'(id));
         chk($sformatf("rsp%0d_data", k), 32'(rsp_dat[k]), 32'(dat));
         chk($sformatf("rsp%0d_err", k), 32'(rsp_err[k]), 32'(err));
         chk($sformatf("rsp%0d_grant_id", k), 32'(gnt_id[k]), 32'(id));
         chk($sformatf("rsp%0d_latency", k), 32'(rsp_cyc[k] - gnt_cyc[k]), 32'd4);
      end
   endtask

   task automatic check_spacing(input int n);
      for (int k = 0; k + 1 < n && k + 1 < gnt_cyc.size(); k++)
         chk($sformatf("grant_spacing%0d", k), 32'(gnt_cyc[k+1] - gnt_cyc[k]), 32'd5);
   endtask

   initial begin
      int g;
      for (int i = 0; i < 4; i++) begin
         r_op[i] = OP_ENQ; r_dat[i] = 16'h0000; rem[i] = 0;
      end
      // Reset with all requesters already asserting ENQ 10,20,30,40.
      set_req(2'd0, OP_ENQ, 16'd10, 1);
      set_req(2'd1, OP_ENQ, 16'd20, 1);
      set_req(2'd2, OP_ENQ, 16'd30, 1);
      set_req(2'd3, OP_ENQ, 16'd40, 1);
      step(); step();
      chk("reset_ready", 32'(bus.o_req_ready), 32'd0);
      chk("reset_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
      chk("reset_busy", 32'(bus.o_busy), 32'd0);
      chk("reset_q_wrt", 32'(bus.o_q_wrt), 32'd0);
      chk("reset_q_read", 32'(bus.o_q_read), 32'd0);
      chk("reset_q_data", 32'(bus.o_q_data), 32'd0);
      chk("reset_rsp_data", 32'(bus.o_rsp_data), 32'd0);
      chk("reset_rsp_err", 32'(bus.o_rsp_err), 32'd0);
      rst_n = 1'b1;
      q_clr = 1'b0;

      // Four simultaneous ENQs granted 0,1,2,3.
      clear_logs();
      run_rsp(4, 40);
      check_rsp(0, 0, 10, 0);
      check_rsp(1, 1, 20, 0);
      check_rsp(2, 2, 30, 0);
      check_rsp(3, 3, 40, 0);
      check_spacing(4);
      chk("t1_wrt_pulses", 32'(wrt_cnt), 32'd4);
      chk("t1_read_pulses", 32'(read_cnt), 32'd0);
      chk("t1_top", 32'(bus.i_q_data), 32'd40);

      // Continuous DEQ on 1 and PEEK on 3 alternate until the queue is empty.
      clear_logs();
      set_req(2'd1, OP_DEQ, 16'd0, 5);
      set_req(2'd3, OP_PEEK, 16'd0, 5);
      run_rsp(10, 80);
      for (int k = 0; k < 10; k++) check_rsp(k, e2_id[k], e2_dat[k], e2_err[k]);
      check_spacing(10);
      chk("t2_read_pulses", 32'(read_cnt), 32'd4);
      chk("t2_wrt_pulses", 32'(wrt_cnt), 32'd0);
      chk("t2_empty", 32'(bus.i_q_empty), 32'd1);

      // Fill the queue, then an ENQ on full is rejected without a write.
      clear_logs();
      set_req(2'd2, OP_ENQ, 16'd5, QS);
      run_rsp(QS, 70);
      for (int k = 0; k < QS; k++) check_rsp(k, 2, 5, 0);
      chk("t3_fill_wrt", 32'(wrt_cnt), 32'(QS));
      chk("t3_full", 32'(bus.i_q_full), 32'd1);
      clear_logs();
      set_req(2'd0, OP_ENQ, 16'd99, 1);
      run_rsp(1, 12);
      check_rsp(0, 0, 5, 1);
      chk("t3_full_no_wrt", 32'(wrt_cnt), 32'd0);
      chk("t3_full_stays", 32'(bus.i_q_full), 32'd1);

      // Queue {50,7}; REPLACE 60 removes 50 and leaves 60 on top.
      q_clr = 1'b1; step(); q_clr = 1'b0;
      clear_logs();
      set_req(2'd0, OP_ENQ, 16'd50, 1);
      set_req(2'd1, OP_ENQ, 16'd7, 1);
      run_rsp(2, 20);
      check_rsp(0, 1, 7, 0);
      check_rsp(1, 0, 50, 0);
      clear_logs();
      set_req(2'd2, OP_REP, 16'd60, 1);
      run_rsp(1, 12);
      check_rsp(0, 2, 50, 0);
      chk("t4_both_pulse", 32'(both_cnt), 32'd1);
      chk("t4_wrt_pulses", 32'(wrt_cnt), 32'd1);
      chk("t4_read_pulses", 32'(read_cnt), 32'd1);
      chk("t4_top", 32'(bus.i_q_data), 32'd60);
      // REPLACE on an empty queue acts as an insert.
      q_clr = 1'b1; step(); q_clr = 1'b0;
      clear_logs();
      set_req(2'd3, OP_REP, 16'd5, 1);
      run_rsp(1, 12);
      check_rsp(0, 3, 5, 0);
      chk("t4e_wrt_pulses", 32'(wrt_cnt), 32'd1);
      chk("t4e_read_pulses", 32'(read_cnt), 32'd0);
      chk("t4e_top", 32'(bus.i_q_data), 32'd5);

      // Reset during SETTLE of a DEQ drops its response and clears the pointer.
      clear_logs();
      set_req(2'd1, OP_DEQ, 16'd0, 1);
      g = 10;
      while (gnt_id.size() < 1 && g > 0) begin
         step();
         g--;
      end
      chk("t5_grant_seen", 32'(gnt_id.size()), 32'd1);
      step();          // ISSUE
      step();          // first SETTLE cycle
      chk("t5_busy_in_settle", 32'(bus.o_busy), 32'd1);
      rst_n = 1'b0;
      step();
      chk("t5_busy_after_reset", 32'(bus.o_busy), 32'd0);
      chk("t5_rsp_valid_after_reset", 32'(bus.o_rsp_valid), 32'd0);
      chk("t5_ready_in_reset", 32'(bus.o_req_ready), 32'd0);
      chk("t5_no_rsp", 32'(rsp_id.size()), 32'd0);
      rst_n = 1'b1;
      clear_logs();
      set_req(2'd0, OP_PEEK, 16'd0, 1);
      set_req(2'd2, OP_PEEK, 16'd0, 1);
      run_rsp(2, 20);
      check_rsp(0, 0, 0, 1);
      check_rsp(1, 2, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
